mem_req_master: RTL and testbench

//  Initiator for the 1 KB word memory (256 x 32-bit): turns single-word commands from the core into
//  the memory's read/write strobe + done handshake. Holds the strobe until the done flag, captures read

---
 rtl/mem_req_master_if.sv | 39 +++
 rtl/mem_req_master.sv | 133 +++++++++++++
 tb/tb_mem_req_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_master_if.sv
// Bundles the command/response handshake from the core and the strobe/done
// handshake to the word memory seen by mem_req_master.
interface mem_req_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_done;
  logic              mem_rd_done;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  mem_rd_data, mem_wr_done, mem_rd_done,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output mem_write, mem_read, mem_write_addr, mem_read_addr, mem_wr_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output mem_rd_data, mem_wr_done, mem_rd_done,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  mem_write, mem_read, mem_write_addr, mem_read_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_req_master.sv
// Single-word memory initiator: holds the read/write strobe until the memory's
// done flag (or a timeout), then returns exactly one response per command.
//
// state    | meaning
// S_IDLE   | ready for a command
// S_WR_REQ | write strobe high, waiting for mem_wr_done
// S_RD_REQ | read strobe high, waiting for mem_rd_done
// S_RESP   | response held until rsp_ready
// S_GAP    | one cycle with strobes low so the memory clears its done flag
module mem_req_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_master_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_RD_REQ = 3'd2,
    S_RESP   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timed_out;

  // cmd_ready is gated by rst so nothing is accepted during the reset cycle
  assign bus.cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign timed_out     = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (bus.cmd_we) begin
            wr_addr_d = bus.cmd_addr;
            wr_data_d = bus.cmd_wdata;
            state_d   = S_WR_REQ;
          end else begin
            rd_addr_d = bus.cmd_addr;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // done is checked before the timeout so a same-cycle done wins
        if (bus.mem_wr_done) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        if (bus.mem_rd_done) begin
          rdata_d = bus.mem_rd_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_write      = (state_q == S_WR_REQ);
  assign bus.mem_read       = (state_q == S_RD_REQ);
  assign bus.mem_write_addr = wr_addr_q;
  assign bus.mem_read_addr  = rd_addr_q;
  assign bus.mem_wr_data    = wr_data_q;
  assign bus.rsp_valid      = (state_q == S_RESP);
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_err        = err_q;
  assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: a latency-programmable word memory plus a plain
// array of expected contents that predicts every response.
module tb_mem_req_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_master_if mif ();
  mem_req_master dut (.clk(clk), .rst(rst), .bus(mif));

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_arr [256] = '{default: 32'd0};
  logic [31:0] ref_mem [256] = '{default: 32'd0};
  int   lat = 0;
  bit   mute = 1'b0;
  int   wcnt = 0;
  int   rcnt = 0;
  int   overlap_cnt = 0;
  logic mdl_wr_done = 1'b0;
  logic mdl_rd_done = 1'b0;
  logic [31:0] mdl_rd_data = 32'hDEAD_BEEF;
  logic inj_wr_done = 1'b0;
  logic inj_rd_done = 1'b0;

  assign mif.mem_wr_done = mdl_wr_done | inj_wr_done;
  assign mif.mem_rd_done = mdl_rd_done | inj_rd_done;
  assign mif.mem_rd_data = mdl_rd_data;

  // memory: done raised lat+1 edges after the strobe is first seen, held until the strobe drops
  always @(posedge clk) begin
    if (mute || !mif.mem_write) begin
      wcnt <= 0;
      mdl_wr_done <= 1'b0;
    end else if (wcnt >= lat) begin
      mem_arr[mif.mem_write_addr] <= mif.mem_wr_data;
      mdl_wr_done <= 1'b1;
    end else begin
      wcnt <= wcnt + 1;
    end
    if (mute || !mif.mem_read) begin
      rcnt <= 0;
      mdl_rd_done <= 1'b0;
      mdl_rd_data <= 32'hDEAD_BEEF;
    end else if (rcnt >= lat) begin
      mdl_rd_data <= mem_arr[mif.mem_read_addr];
      mdl_rd_done <= 1'b1;
    end else begin
      rcnt <= rcnt + 1;
    end
    if (mif.mem_write && mif.mem_read) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit we, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output logic err, output int strobes,
                           output bit got_rsp, output bit addr_ok);
    int n;
    n = 0;
    mif.cmd_we = we; mif.cmd_addr = a; mif.cmd_wdata = d; mif.cmd_valid = 1'b1;
    while (mif.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    mif.cmd_valid = 1'b0;
    strobes = 0; addr_ok = 1'b1; n = 0;
    while (mif.rsp_valid !== 1'b1 && n < 200) begin
      if (mif.mem_write === 1'b1) begin
        strobes++;
        if (!we || mif.mem_write_addr !== a || mif.mem_wr_data !== d) addr_ok = 1'b0;
      end
      if (mif.mem_read === 1'b1) begin
        strobes++;
        if (we || mif.mem_read_addr !== a) addr_ok = 1'b0;
      end
      tick(); n++;
    end
    got_rsp = (mif.rsp_valid === 1'b1);
    rdata = mif.rsp_rdata;
    err = mif.rsp_err;
  endtask

  task automatic finish_rsp();
    mif.rsp_ready = 1'b1;
    tick();
    mif.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      tests++;
      if ({mif.cmd_ready, mif.rsp_valid, mif.rsp_err, mif.busy, mif.mem_write, mif.mem_read} !== 6'b0 ||
          mif.rsp_rdata !== 32'd0 || mif.mem_write_addr !== 8'd0 || mif.mem_read_addr !== 8'd0 ||
          mif.mem_wr_data !== 32'd0) begin
        fails++;
        $display("FAIL reset_outputs got ready=%b busy=%b wr=%b rd=%b rsp=%b exp all 0",
                 mif.cmd_ready, mif.busy, mif.mem_write, mif.mem_read, mif.rsp_valid);
      end
    end
    rst = 1'b0;
    tick();
    tests++;
    if (mif.cmd_ready !== 1'b1 || mif.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", mif.cmd_ready, mif.busy);
    end
  endtask

  task automatic test_write();
    logic [31:0] rd; logic er; int st; bit got, aok;
    lat = 1;
    issue_cmd(1'b1, 8'd0, 32'd1000, rd, er, st, got, aok);
    ref_mem[0] = 32'd1000;
    tests++;
    if (!got || er !== 1'b0 || rd !== 32'd0 || !aok || st != lat + 2) begin
      fails++;
      $display("FAIL write0 got rsp=%0d err=%b rdata=%0d addr_ok=%0d strobes=%0d exp 1/0/0/1/%0d",
               got, er, rd, aok, st, lat + 2);
    end
    finish_rsp();
    tests++;
    if (mif.busy !== 1'b1 || mif.cmd_ready !== 1'b0 || mif.mem_write !== 1'b0) begin
      fails++;
      $display("FAIL write0_gap got busy=%b ready=%b wr=%b exp 1/0/0", mif.busy, mif.cmd_ready, mif.mem_write);
    end
    tick();
    tests++;
    if (mif.busy !== 1'b0 || mif.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL write0_idle got busy=%b ready=%b exp 0/1", mif.busy, mif.cmd_ready);
    end
  endtask

  task automatic test_read();
    logic [31:0] rd; logic er; int st; bit got, aok;
    lat = 3;
    issue_cmd(1'b0, 8'd0, 32'd0, rd, er, st, got, aok);
    tests++;
    if (!got || er !== 1'b0 || rd !== 32'd1000 || !aok || st != lat + 2) begin
      fails++;
      $display("FAIL read0 got rsp=%0d err=%b rdata=%0d addr_ok=%0d strobes=%0d exp 1/0/1000/1/%0d",
               got, er, rd, aok, st, lat + 2);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int n, ov0;
    bit saw_rsp;
    ov0 = overlap_cnt;
    lat = 0;
    mif.rsp_ready = 1'b1;
    mif.cmd_we = 1'b1; mif.cmd_addr = 8'd255; mif.cmd_wdata = 32'd88889; mif.cmd_valid = 1'b1;
    n = 0;
    while (mif.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    mif.cmd_we = 1'b0; mif.cmd_wdata = 32'd0;
    n = 0; saw_rsp = 1'b0;
    while (mif.cmd_ready !== 1'b1 && n < 200) begin
      if (mif.rsp_valid === 1'b1) saw_rsp = 1'b1;
      tick(); n++;
    end
    ref_mem[255] = 32'd88889;
    tests++;
    if (n != lat + 4 || !saw_rsp) begin
      fails++;
      $display("FAIL b2b_gap got wait=%0d saw_rsp=%0d exp %0d/1", n, saw_rsp, lat + 4);
    end
    tick();
    mif.cmd_valid = 1'b0;
    n = 0;
    while (mif.rsp_valid !== 1'b1 && n < 200) begin tick(); n++; end
    tests++;
    if (mif.rsp_valid !== 1'b1 || mif.rsp_rdata !== 32'd88889 || mif.rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read got rsp=%b rdata=%0d err=%b exp 1/88889/0", mif.rsp_valid, mif.rsp_rdata, mif.rsp_err);
    end
    tick();
    mif.rsp_ready = 1'b0;
    tick();
    tests++;
    if (overlap_cnt != ov0) begin
      fails++;
      $display("FAIL b2b_overlap got %0d overlapping cycles exp 0", overlap_cnt - ov0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int st; bit got, aok, bad;
    mute = 1'b1;
    issue_cmd(1'b1, 8'd10, 32'h1234_5678, rd, er, st, got, aok);
    tests++;
    if (!got || er !== 1'b1 || rd !== 32'd0 || st != 64) begin
      fails++;
      $display("FAIL timeout_wr got rsp=%0d err=%b rdata=%0d strobes=%0d exp 1/1/0/64", got, er, rd, st);
    end
    finish_rsp();
    tick();
    inj_wr_done = 1'b1; inj_rd_done = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (mif.busy !== 1'b0 || mif.rsp_valid !== 1'b0) bad = 1'b1;
    end
    inj_wr_done = 1'b0; inj_rd_done = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL late_done got busy=%b rsp=%b exp 0/0", mif.busy, mif.rsp_valid);
    end
    issue_cmd(1'b0, 8'd20, 32'd0, rd, er, st, got, aok);
    tests++;
    if (!got || er !== 1'b1 || rd !== 32'd0 || st != 64) begin
      fails++;
      $display("FAIL timeout_rd got rsp=%0d err=%b rdata=%0d strobes=%0d exp 1/1/0/64", got, er, rd, st);
    end
    finish_rsp();
    mute = 1'b0;
  endtask

  task automatic test_done_vs_timeout();
    logic [31:0] rd; logic er; int st; bit got, aok;
    logic [31:0] d;
    d = $urandom;
    lat = 62;
    issue_cmd(1'b1, 8'd30, d, rd, er, st, got, aok);
    ref_mem[30] = d;
    tests++;
    if (!got || er !== 1'b0 || st != 64) begin
      fails++;
      $display("FAIL done_wins_wr got rsp=%0d err=%b strobes=%0d exp 1/0/64", got, er, st);
    end
    finish_rsp();
    lat = 63;
    issue_cmd(1'b0, 8'd30, 32'd0, rd, er, st, got, aok);
    tests++;
    if (!got || er !== 1'b1 || rd !== 32'd0 || st != 64) begin
      fails++;
      $display("FAIL late_by_one got rsp=%0d err=%b rdata=%0d strobes=%0d exp 1/1/0/64", got, er, rd, st);
    end
    finish_rsp();
    lat = 62;
    issue_cmd(1'b0, 8'd30, 32'd0, rd, er, st, got, aok);
    tests++;
    if (!got || er !== 1'b0 || rd !== ref_mem[30] || st != 64) begin
      fails++;
      $display("FAIL done_wins_rd got err=%b rdata=%0d strobes=%0d exp 0/%0d/64", er, rd, st, ref_mem[30]);
    end
    finish_rsp();
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int st; bit got, aok;
    lat = 2;
    issue_cmd(1'b0, 8'd0, 32'd0, rd, er, st, got, aok);
    tests++;
    if (!got || rd !== ref_mem[0]) begin
      fails++;
      $display("FAIL stall_first got rsp=%0d rdata=%0d exp 1/%0d", got, rd, ref_mem[0]);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (mif.rsp_valid !== 1'b1 || mif.rsp_rdata !== ref_mem[0] || mif.rsp_err !== 1'b0 ||
          mif.cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold cycle %0d got rsp=%b rdata=%0d ready=%b exp 1/%0d/0",
                 i, mif.rsp_valid, mif.rsp_rdata, mif.cmd_ready, ref_mem[0]);
      end
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    mute = 1'b1;
    mif.cmd_we = 1'b1; mif.cmd_addr = 8'd40; mif.cmd_wdata = 32'hCAFE; mif.cmd_valid = 1'b1;
    n = 0;
    while (mif.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    mif.cmd_valid = 1'b0;
    tick(); tick();
    tests++;
    if (mif.mem_write !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre got wr=%b exp 1", mif.mem_write);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (mif.mem_write !== 1'b0 || mif.rsp_valid !== 1'b0 || mif.busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_drop got wr=%b rsp=%b busy=%b exp 0/0/0", mif.mem_write, mif.rsp_valid, mif.busy);
    end
    rst = 1'b0;
    mute = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (mif.rsp_valid !== 1'b0 || mif.mem_write !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad || mif.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_after got rsp=%b ready=%b exp 0/1", mif.rsp_valid, mif.cmd_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_rd; logic er; int st; bit got, aok, we;
    logic [7:0] a;
    int ov0;
    ov0 = overlap_cnt;
    for (int i = 0; i < 40; i++) begin
      we  = bit'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7) * 37) : 8'($urandom_range(0, 255));
      d   = $urandom;
      lat = $urandom_range(0, 4);
      exp_rd = we ? 32'd0 : ref_mem[a];
      issue_cmd(we, a, d, rd, er, st, got, aok);
      if (we) ref_mem[a] = d;
      tests++;
      if (!got || er !== 1'b0 || rd !== exp_rd || !aok || st != lat + 2) begin
        fails++;
        $display("FAIL random #%0d we=%0d addr=%0d got rsp=%0d err=%b rdata=%h aok=%0d strobes=%0d exp 1/0/%h/1/%0d",
                 i, we, a, got, er, rd, aok, st, exp_rd, lat + 2);
      end
      repeat ($urandom_range(0, 3)) tick();
      finish_rsp();
    end
    tests++;
    if (overlap_cnt != ov0) begin
      fails++;
      $display("FAIL random_overlap got %0d overlapping cycles exp 0", overlap_cnt - ov0);
    end
  endtask

  initial begin
    rst = 1'b1;
    mif.cmd_valid = 1'b0; mif.cmd_we = 1'b0; mif.cmd_addr = 8'd0; mif.cmd_wdata = 32'd0;
    mif.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_done_vs_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
